piezo_tone_decoder: RTL and testbench

//  Receive-side counterpart of the piezo alert driver: decodes the square-wave audio stream back into
//  the alert class that produced it (over-speed, battery-low, moving).

---
 rtl/piezo_tone_decoder_if.sv | 25 ++
 rtl/piezo_tone_decoder.sv | 191 +++++++++++++++++++
 tb/tb_piezo_tone_decoder.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/piezo_tone_decoder_if.sv
// Audio-monitor bundle for the piezo tone decoder.
// slave: decoder side; master: driver/observer side.
interface piezo_tone_decoder_if;
  logic       audio_i;
  logic       tone_valid_o;
  logic [1:0] tone_id_o;
  logic       tone_chg_o;
  logic [7:0] burst_cnt_o;

  modport slave (
    input  audio_i,
    output tone_valid_o,
    output tone_id_o,
    output tone_chg_o,
    output burst_cnt_o
  );

  modport master (
    output audio_i,
    input  tone_valid_o,
    input  tone_id_o,
    input  tone_chg_o,
    input  burst_cnt_o
  );
endinterface

// File: rtl/piezo_tone_decoder.sv
// Piezo tone decoder: recovers alert class from the square-wave audio stream.
// Ports: clk, rst_n (async low), bus.slave (audio_i in; tone_valid/id/chg, burst_cnt out).
module piezo_tone_decoder #(
  parameter int CNT_W     = 18,
  parameter int HP_OVR    = 8192,
  parameter int HP_BATT   = 16384,
  parameter int HP_MOV    = 65536,
  parameter int TOL       = 256,
  parameter int MATCH_CNT = 4,
  parameter int SILENCE   = 131072
) (
  input  logic clk,
  input  logic rst_n,
  piezo_tone_decoder_if.slave bus
);

  localparam int MW = $clog2(MATCH_CNT + 1);
  localparam int MV = CNT_W + 1;

  localparam logic [MV-1:0]    OVR_V   = MV'(HP_OVR);
  localparam logic [MV-1:0]    BATT_V  = MV'(HP_BATT);
  localparam logic [MV-1:0]    MOV_V   = MV'(HP_MOV);
  localparam logic [MV-1:0]    TOL_V   = MV'(TOL);
  localparam logic [CNT_W-1:0] SIL_TH  = CNT_W'(SILENCE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [MW-1:0]    MATCH_V = MW'(MATCH_CNT);

  localparam logic [1:0] T_NONE = 2'b00;
  localparam logic [1:0] T_OVR  = 2'b01;
  localparam logic [1:0] T_BATT = 2'b10;
  localparam logic [1:0] T_MOV  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEAS,
    S_LOCK
  } state_e;

  state_e           state_q, state_d;
  logic             sync1_q, sync2_q, dly_q;
  logic [CNT_W-1:0] hp_cnt_q;
  logic [1:0]       cand_q, cand_d;
  logic [MW-1:0]    match_q, match_d;
  logic             valid_q, valid_d;
  logic [1:0]       id_q, id_d;
  logic             chg_q;
  logic [7:0]       burst_q, burst_d;

  logic             edge_w;
  logic             sil_w;
  logic [MV-1:0]    m_w;
  logic [1:0]       cls;
  logic [MW-1:0]    match_one;
  logic [MW-1:0]    match_up;

  function automatic logic near(
    input logic [MV-1:0] m,
    input logic [MV-1:0] hp
  );
    logic [MV-1:0] d;
    d = (m >= hp) ? (m - hp) : (hp - m);
    return d <= TOL_V;
  endfunction

  assign edge_w = sync2_q ^ dly_q;
  assign sil_w  = (hp_cnt_q == SIL_TH) && !edge_w;
  assign m_w    = {1'b0, hp_cnt_q} + MV'(1);

  always_comb begin
    cls = T_NONE;
    if (near(m_w, OVR_V))
      cls = T_OVR;
    else if (near(m_w, BATT_V))
      cls = T_BATT;
    else if (near(m_w, MOV_V))
      cls = T_MOV;
  end

  assign match_one = (cls != T_NONE) ? MW'(1) : '0;

  // Extend the run only for a repeated real tone; otherwise restart on cls.
  always_comb begin
    match_up = match_one;
    if (cls == cand_q && cls != T_NONE)
      match_up = (match_q == MATCH_V) ? match_q
                                      : match_q + MW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      dly_q    <= 1'b0;
      hp_cnt_q <= '0;
    end else begin
      sync1_q <= bus.audio_i;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
      if (edge_w)
        hp_cnt_q <= '0;
      else if (hp_cnt_q != CNT_MAX)
        hp_cnt_q <= hp_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    match_d = match_q;
    valid_d = valid_q;
    id_d    = id_q;
    burst_d = burst_q;
    unique case (state_q)
      S_IDLE: begin
        if (edge_w)
          state_d = S_MEAS;
      end
      S_MEAS: begin
        if (edge_w) begin
          cand_d  = cls;
          match_d = match_up;
          if (match_up >= MATCH_V) begin
            state_d = S_LOCK;
            valid_d = 1'b1;
            id_d    = cls;
          end
        end else if (sil_w) begin
          state_d = S_IDLE;
          cand_d  = T_NONE;
          match_d = '0;
          valid_d = 1'b0;
          id_d    = T_NONE;
        end
      end
      S_LOCK: begin
        if (edge_w) begin
          if (cls != id_q) begin
            state_d = S_MEAS;
            valid_d = 1'b0;
            id_d    = T_NONE;
            burst_d = burst_q + 8'd1;
            cand_d  = cls;
            match_d = match_one;
            // Single-match lock: jump straight to the new tone.
            if (match_one >= MATCH_V) begin
              state_d = S_LOCK;
              valid_d = 1'b1;
              id_d    = cls;
            end
          end
        end else if (sil_w) begin
          state_d = S_IDLE;
          cand_d  = T_NONE;
          match_d = '0;
          valid_d = 1'b0;
          id_d    = T_NONE;
          burst_d = burst_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cand_q  <= T_NONE;
      match_q <= '0;
      valid_q <= 1'b0;
      id_q    <= T_NONE;
      chg_q   <= 1'b0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      match_q <= match_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      chg_q   <= (id_d != id_q);
      burst_q <= burst_d;
    end
  end

  assign bus.tone_valid_o = valid_q;
  assign bus.tone_id_o    = id_q;
  assign bus.tone_chg_o   = chg_q;
  assign bus.burst_cnt_o  = burst_q;

endmodule

// File: tb/tb_piezo_tone_decoder.sv
// Bench for piezo_tone_decoder with scaled-down periods.
// Expected tone changes are queued with stimulus and popped on tone_chg.
module tb_piezo_tone_decoder;

  localparam int CNT_W     = 10;
  localparam int HP_OVR    = 64;
  localparam int HP_BATT   = 128;
  localparam int HP_MOV    = 256;
  localparam int TOL       = 4;
  localparam int MATCH_CNT = 4;
  localparam int SILENCE   = 260;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  piezo_tone_decoder_if bus();

  piezo_tone_decoder #(
    .CNT_W    (CNT_W),
    .HP_OVR   (HP_OVR),
    .HP_BATT  (HP_BATT),
    .HP_MOV   (HP_MOV),
    .TOL      (TOL),
    .MATCH_CNT(MATCH_CNT),
    .SILENCE  (SILENCE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [1:0] id;
    logic       valid;
    logic [7:0] burst;
  } ev_t;

  ev_t sb[$];
  int  total = 0;
  int  bad = 0;
  int  eb = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(logic [1:0] id, logic v, int b);
    ev_t e;
    e.id    = id;
    e.valid = v;
    e.burst = 8'(b);
    sb.push_back(e);
  endtask

  task automatic tog(int n, int p);
    repeat (n) begin
      repeat (p) @(posedge clk);
      #1 bus.audio_i = ~bus.audio_i;
    end
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  ev_t got;
  always @(negedge clk) begin
    if (rst_n && bus.tone_chg_o) begin
      if (sb.size() == 0) begin
        chk("unexp_chg", 32'(bus.tone_chg_o), 0);
      end else begin
        got = sb.pop_front();
        chk("chg_id", 32'(bus.tone_id_o), 32'(got.id));
        chk("chg_valid", 32'(bus.tone_valid_o), 32'(got.valid));
        chk("chg_burst", 32'(bus.burst_cnt_o), 32'(got.burst));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    bus.audio_i = 1'b0;
    rst_n = 1'b0;
    idle(3);
    chk("rst_valid", 32'(bus.tone_valid_o), 0);
    chk("rst_id", 32'(bus.tone_id_o), 0);
    chk("rst_chg", 32'(bus.tone_chg_o), 0);
    chk("rst_burst", 32'(bus.burst_cnt_o), 0);
    rst_n = 1'b1;
    idle(3);

    // Lock on over-speed, then move to battery-low.
    sb_push(2'b01, 1'b1, 0);
    tog(6, HP_OVR);
    chk("ovr_valid", 32'(bus.tone_valid_o), 1);
    chk("ovr_id", 32'(bus.tone_id_o), 1);
    eb = 1;
    sb_push(2'b00, 1'b0, eb);
    sb_push(2'b10, 1'b1, eb);
    tog(4, HP_BATT);
    idle(5);
    chk("batt_id", 32'(bus.tone_id_o), 2);
    chk("batt_burst", 32'(bus.burst_cnt_o), 32'(eb));

    eb++;
    sb_push(2'b00, 1'b0, eb);
    idle(SILENCE + 5);
    chk("sil_valid", 32'(bus.tone_valid_o), 0);
    chk("sil_id", 32'(bus.tone_id_o), 0);
    chk("sil_burst", 32'(bus.burst_cnt_o), 32'(eb));

    // Tolerance edge: +TOL locks, +TOL+1 never does.
    sb_push(2'b10, 1'b1, eb);
    tog(5, HP_BATT + TOL);
    idle(5);
    chk("tol_id", 32'(bus.tone_id_o), 2);
    eb++;
    sb_push(2'b00, 1'b0, eb);
    idle(SILENCE + 5);
    tog(8, HP_BATT + TOL + 1);
    idle(5);
    chk("ntol_valid", 32'(bus.tone_valid_o), 0);
    chk("ntol_id", 32'(bus.tone_id_o), 0);
    idle(SILENCE + 5);
    chk("ntol_burst", 32'(bus.burst_cnt_o), 32'(eb));

    // Moving tone; next edge lands on the silence threshold.
    sb_push(2'b11, 1'b1, eb);
    tog(6, HP_MOV);
    tog(1, SILENCE);
    idle(5);
    chk("thr_valid", 32'(bus.tone_valid_o), 1);
    chk("thr_id", 32'(bus.tone_id_o), 3);
    eb++;
    sb_push(2'b00, 1'b0, eb);
    idle(SILENCE + 5);
    chk("mov_burst", 32'(bus.burst_cnt_o), 32'(eb));

    // Gated over-speed bursts.
    for (int b = 0; b < 3; b++) begin
      sb_push(2'b01, 1'b1, eb);
      tog(8, HP_OVR);
      eb++;
      sb_push(2'b00, 1'b0, eb);
      idle(2 * SILENCE);
      chk("gap_valid", 32'(bus.tone_valid_o), 0);
    end
    chk("gate_burst", 32'(bus.burst_cnt_o), 32'(eb));

    // Reset while locked.
    sb_push(2'b01, 1'b1, eb);
    tog(6, HP_OVR);
    chk("pre_rst_valid", 32'(bus.tone_valid_o), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.tone_valid_o), 0);
    chk("mid_rst_id", 32'(bus.tone_id_o), 0);
    chk("mid_rst_burst", 32'(bus.burst_cnt_o), 0);
    chk("mid_rst_chg", 32'(bus.tone_chg_o), 0);
    eb = 0;
    bus.audio_i = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(3);
    sb_push(2'b01, 1'b1, eb);
    tog(5, HP_OVR);
    idle(5);
    chk("post_rst_id", 32'(bus.tone_id_o), 1);
    chk("post_rst_burst", 32'(bus.burst_cnt_o), 0);
    eb++;
    sb_push(2'b00, 1'b0, eb);
    idle(SILENCE + 5);
    chk("sb_left", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
